// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op encodings, fault codes,
// FSM states and small decode helpers used when a request is accepted.
package lsu_pkg;

    localparam int LSU_DATA_W      = 32;
    localparam int LSU_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        MEMOP_LB  = 3'b000,
        MEMOP_LH  = 3'b001,
        MEMOP_LW  = 3'b010,
        MEMOP_LBU = 3'b100,
        MEMOP_LHU = 3'b101
    } memop_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic memop_legal(input logic [2:0] op);
        case (op)
            MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    function automatic logic memop_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEMOP_LH, MEMOP_LHU: return off[0];
            MEMOP_LW:            return off != 2'b00;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] memop_mask(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEMOP_LB, MEMOP_LBU: return 4'b0001 << off;
            MEMOP_LH, MEMOP_LHU: return 4'b0011 << off;
            default:             return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load data extraction: moves the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to the memory op.
module lsu_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  memop_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = '0;
        case (memop_i)
            MEMOP_LB:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            MEMOP_LH:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_LW:  data_o = shifted;
            MEMOP_LBU: data_o = {24'h0, shifted[7:0]};
            MEMOP_LHU: data_o = {16'h0, shifted[15:0]};
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit: accepts one access, checks alignment, drives a word-aligned
// memory request, waits for ack (with timeout) and returns one response.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH  = LSU_DATA_W,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_memop_i,
    input  logic                  req_wr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_wmask_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [1:0]            resp_fault_o
);

    // The timeout fires on the last of TIMEOUT_CYC wait cycles; an ack in that cycle still wins.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_e                  state_q;
    logic [2:0]              memop_q;
    logic [1:0]              offset_q;
    logic                    wr_q;
    logic [7:0]              cnt_q;
    logic                    mem_req_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q;
    logic                    mem_we_q;
    logic [3:0]              mem_wmask_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic [1:0]              resp_fault_q;
    logic [DATA_WIDTH-1:0]   ext_data;

    lsu_ext u_ext (
        .rdata_i  (mem_rdata_i),
        .offset_i (offset_q),
        .memop_i  (memop_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            memop_q      <= '0;
            offset_q     <= '0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wmask_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_fault_q <= FAULT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        memop_q     <= req_memop_i;
                        offset_q    <= req_addr_i[1:0];
                        wr_q        <= req_wr_i;
                        mem_addr_q  <= {req_addr_i[DATA_WIDTH-1:2], 2'b00};
                        mem_wmask_q <= memop_mask(req_memop_i, req_addr_i[1:0]);
                        mem_wdata_q <= req_wdata_i << {req_addr_i[1:0], 3'b000};
                        // Faulted accesses answer straight away and never reach memory.
                        if (!memop_legal(req_memop_i)) begin
                            resp_fault_q <= FAULT_ILLEGAL;
                            resp_data_q  <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (memop_misaligned(req_memop_i, req_addr_i[1:0])) begin
                            resp_fault_q <= FAULT_MISALIGN;
                            resp_data_q  <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= req_wr_i;
                            state_q   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_data_q  <= wr_q ? '0 : ext_data;
                        resp_fault_q <= FAULT_NONE;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_data_q  <= '0;
                        resp_fault_q <= FAULT_TIMEOUT;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wmask_o  = mem_wmask_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_fault_o = resp_fault_q;

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed spec scenarios plus random
// accesses compared against an arithmetic reference model.
module tb_lsu_align;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [2:0]  reqMemop;
    logic        reqWr;
    logic [31:0] reqWdata;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memWe;
    logic [3:0]  memWmask;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic [1:0]  respFault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_align #(.DATA_WIDTH(32), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_addr_i   (reqAddr),
        .req_memop_i  (reqMemop),
        .req_wr_i     (reqWr),
        .req_wdata_i  (reqWdata),
        .mem_req_o    (memReq),
        .mem_addr_o   (memAddr),
        .mem_we_o     (memWe),
        .mem_wmask_o  (memWmask),
        .mem_wdata_o  (memWdata),
        .mem_ack_i    (memAck),
        .mem_rdata_i  (memRdata),
        .resp_valid_o (respValid),
        .resp_ready_i (respReady),
        .resp_data_o  (respData),
        .resp_fault_o (respFault)
    );

    // Outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: access size, legality and alignment from the op; ackK = wait cycles before ack.
    task automatic refModel(input logic [2:0] op, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int ackK,
                            output logic [1:0] fault, output logic [31:0] data,
                            output logic [3:0] mask, output logic [31:0] wd, output bit toMem);
        int          size;
        int          off;
        bit          legal;
        logic [63:0] val;
        logic [7:0]  m;
        legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
        case (op[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            default: size = 4;
        endcase
        off   = int'(addr % 4);
        m     = 8'(((1 << size) - 1) << off);
        mask  = m[3:0];
        wd    = wdata << (8 * off);
        data  = 32'h0;
        toMem = 1'b0;
        if (!legal) begin
            fault = 2'b10;
        end else if ((off % size) != 0) begin
            fault = 2'b01;
        end else begin
            toMem = 1'b1;
            if (ackK >= TIMEOUT) begin
                fault = 2'b11;
            end else begin
                fault = 2'b00;
                if (!wr) begin
                    val = ({32'h0, rdata} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
                    if (!op[2] && size < 4 && val >= (64'd1 << (8 * size - 1)))
                        val = val - (64'd1 << (8 * size));
                    data = val[31:0];
                end
            end
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] addr,
                                 input logic wr, input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int ackK, input int holdCycles);
        logic [1:0]  expFault;
        logic [31:0] expData;
        logic [3:0]  expMask;
        logic [31:0] expWdata;
        bit          toMem;
        int          waited;
        refModel(op, addr, wr, wdata, rdata, ackK, expFault, expData, expMask, expWdata, toMem);
        waited = 0;
        while (!reqReady && waited < 20) begin
            step();
            waited++;
        end
        checkOutput({name, ".req_ready"}, 32'(reqReady), 32'd1);
        reqValid = 1'b1;
        reqMemop = op;
        reqAddr  = addr;
        reqWr    = wr;
        reqWdata = wdata;
        step();
        reqValid = 1'b0;
        reqMemop = 3'($urandom);
        reqAddr  = $urandom;
        reqWdata = $urandom;
        if (toMem) begin
            checkOutput({name, ".mem_req"}, 32'(memReq), 32'd1);
            checkOutput({name, ".mem_addr"}, memAddr, {addr[31:2], 2'b00});
            checkOutput({name, ".mem_we"}, 32'(memWe), 32'(wr));
            checkOutput({name, ".mem_wmask"}, 32'(memWmask), 32'(expMask));
            if (wr)
                checkOutput({name, ".mem_wdata"}, memWdata, expWdata);
            for (int k = 0; k < TIMEOUT; k++) begin
                step();
                if (k == ackK) begin
                    checkOutput({name, ".resp_early"}, 32'(respValid), 32'd0);
                    memAck   = 1'b1;
                    memRdata = rdata;
                    step();
                    memAck   = 1'b0;
                    memRdata = $urandom;
                    break;
                end
            end
            if (ackK >= TIMEOUT)
                step();
            checkOutput({name, ".mem_req_drop"}, 32'(memReq), 32'd0);
            checkOutput({name, ".mem_we_drop"}, 32'(memWe), 32'd0);
        end else begin
            checkOutput({name, ".no_mem_req"}, 32'(memReq), 32'd0);
        end
        checkOutput({name, ".resp_valid"}, 32'(respValid), 32'd1);
        checkOutput({name, ".resp_fault"}, 32'(respFault), 32'(expFault));
        checkOutput({name, ".resp_data"}, respData, expData);
        for (int h = 0; h < holdCycles; h++) begin
            step();
            checkOutput({name, ".hold_valid"}, 32'(respValid), 32'd1);
            checkOutput({name, ".hold_data"}, respData, expData);
            checkOutput({name, ".hold_fault"}, 32'(respFault), 32'(expFault));
        end
        respReady = 1'b1;
        step();
        respReady = 1'b0;
        checkOutput({name, ".resp_clear"}, 32'(respValid), 32'd0);
        checkOutput({name, ".ready_again"}, 32'(reqReady), 32'd1);
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        rstN      = 1'b0;
        reqValid  = 1'b0;
        reqAddr   = '0;
        reqMemop  = '0;
        reqWr     = 1'b0;
        reqWdata  = '0;
        memAck    = 1'b0;
        memRdata  = $urandom;
        respReady = 1'b0;
        repeat (3) step();
        checkOutput("reset.mem_req", 32'(memReq), 32'd0);
        checkOutput("reset.mem_addr", memAddr, 32'd0);
        checkOutput("reset.mem_wmask", 32'(memWmask), 32'd0);
        checkOutput("reset.resp_valid", 32'(respValid), 32'd0);
        checkOutput("reset.resp_fault", 32'(respFault), 32'd0);
        #3;
        rstN = 1'b1;
        step();
        checkOutput("reset.req_ready", 32'(reqReady), 32'd1);

        applyStimulus("lw_basic", 3'b010, 32'h8000_0004, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0);
        applyStimulus("lb_sign", 3'b000, 32'h0000_1003, 1'b0, 32'h0, 32'h80AA_BBCC, 0, 0);
        applyStimulus("lbu_zero", 3'b100, 32'h0000_1003, 1'b0, 32'h0, 32'h80AA_BBCC, 1, 0);
        applyStimulus("lh_sign", 3'b001, 32'h0000_2002, 1'b0, 32'h0, 32'h9234_5678, 2, 0);
        applyStimulus("lhu_zero", 3'b101, 32'h0000_2000, 1'b0, 32'h0, 32'h1234_F678, 0, 0);
        applyStimulus("sh_store", 3'b001, 32'h0000_3002, 1'b1, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
        applyStimulus("sb_store", 3'b000, 32'h0000_3001, 1'b1, 32'h0000_00EE, 32'h0, 1, 0);
        applyStimulus("lw_misalign", 3'b010, 32'h0000_4002, 1'b0, 32'h0, 32'h0, 0, 0);
        applyStimulus("lh_misalign", 3'b101, 32'h0000_4003, 1'b0, 32'h0, 32'h0, 0, 0);
        applyStimulus("illegal_prio", 3'b011, 32'h0000_4001, 1'b0, 32'h0, 32'h0, 0, 0);
        applyStimulus("timeout", 3'b010, 32'h0000_5000, 1'b0, 32'h0, 32'h0, TIMEOUT, 0);
        applyStimulus("ack_on_last", 3'b010, 32'h0000_5004, 1'b0, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 0);
        applyStimulus("resp_stall", 3'b000, 32'h0000_6002, 1'b0, 32'h0, 32'h00F1_0000, 0, 5);

        // Reset while waiting for memory must abort the access without a response.
        reqValid = 1'b1;
        reqMemop = 3'b010;
        reqAddr  = 32'h0000_7008;
        reqWr    = 1'b1;
        reqWdata = 32'hA5A5_A5A5;
        step();
        reqValid = 1'b0;
        step();
        step();
        rstN = 1'b0;
        #2;
        checkOutput("abort.mem_req", 32'(memReq), 32'd0);
        checkOutput("abort.mem_we", 32'(memWe), 32'd0);
        checkOutput("abort.mem_addr", memAddr, 32'd0);
        checkOutput("abort.mem_wdata", memWdata, 32'd0);
        checkOutput("abort.mem_wmask", 32'(memWmask), 32'd0);
        checkOutput("abort.resp_valid", 32'(respValid), 32'd0);
        checkOutput("abort.resp_data", respData, 32'd0);
        checkOutput("abort.req_ready", 32'(reqReady), 32'd1);
        #4;
        rstN = 1'b1;
        step();
        step();
        checkOutput("abort.no_resp", 32'(respValid), 32'd0);
        checkOutput("abort.idle_mem", 32'(memReq), 32'd0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), $urandom,
                          1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
